// File: rtl/ysyx_24070017_idu_stage.sv
// RISC-V base-integer decode stage: one registered slot between IFU and EXU.
// Splits the instruction into fields, selects the format immediate and flags rd writes / illegal encodings.
module ysyx_24070017_idu_stage #(
   parameter int XLEN     = 32,
   parameter bit RV64_OPS = (XLEN == 64)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_imm_type,
   output logic            out_rd_wen,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [6:0]      opc;
   logic [31:0]     imm32;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_type;
   logic            dec_writes;
   logic            dec_wen;
   logic            dec_illegal;
   logic            accept;

   assign opc = in_inst[6:0];

   always_comb begin
      imm32       = '0;
      dec_type    = FMT_R;
      dec_writes  = 1'b0;
      dec_illegal = 1'b0;
      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            dec_type   = FMT_U;
            imm32      = {in_inst[31:12], 12'b0};
            dec_writes = 1'b1;
         end
         OPC_JAL: begin
            dec_type   = FMT_J;
            imm32      = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            dec_writes = 1'b1;
         end
         OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
            dec_type   = FMT_I;
            imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
            dec_writes = 1'b1;
         end
         // FENCE and ECALL/EBREAK share funct3=000 and never write rd
         OPC_SYSTEM, OPC_MISC_MEM: begin
            dec_type   = FMT_I;
            imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
            dec_writes = (in_inst[14:12] != 3'b000);
         end
         OPC_OP_IMM32: begin
            if (RV64_OPS) begin
               dec_type   = FMT_I;
               imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
               dec_writes = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            dec_type = FMT_S;
            imm32    = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         end
         OPC_BRANCH: begin
            dec_type = FMT_B;
            imm32    = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
         end
         OPC_OP: begin
            dec_writes = 1'b1;
         end
         OPC_OP32: begin
            if (RV64_OPS) dec_writes = 1'b1;
            else          dec_illegal = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   assign dec_imm  = XLEN'($signed(imm32));
   assign dec_wen  = dec_writes & (in_inst[11:7] != 5'd0);
   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready & ~flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_opcode   <= '0;
         out_rd       <= '0;
         out_rs1      <= '0;
         out_rs2      <= '0;
         out_funct3   <= '0;
         out_funct7   <= '0;
         out_imm      <= '0;
         out_imm_type <= '0;
         out_rd_wen   <= 1'b0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_opcode   <= opc;
         out_rd       <= in_inst[11:7];
         out_rs1      <= in_inst[19:15];
         out_rs2      <= in_inst[24:20];
         out_funct3   <= in_inst[14:12];
         out_funct7   <= in_inst[31:25];
         out_imm      <= dec_imm;
         out_imm_type <= dec_type;
         out_rd_wen   <= dec_wen;
         out_illegal  <= dec_illegal;
      end else if (out_valid & out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ysyx_24070017_idu_stage.sv
// Bench for the decode stage: table of instruction vectors through a scoreboard, plus
// backpressure, flush, RV64 and mid-hold reset sequences.
module tb_ysyx_24070017_idu_stage;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
      logic [31:0] imm;
      logic [2:0]  ty;
      logic        wen;
      logic        ill;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [63:0] in_pc;
   logic        flush;
   logic        out_ready;

   logic        a_in_ready, a_valid, a_wen, a_ill;
   logic [31:0] a_pc, a_imm;
   logic [6:0]  a_opc, a_f7;
   logic [4:0]  a_rd, a_rs1, a_rs2;
   logic [2:0]  a_f3, a_ty;

   logic        b_in_ready, b_valid, b_wen, b_ill;
   logic [63:0] b_pc, b_imm;
   logic [6:0]  b_opc, b_f7;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [2:0]  b_f3, b_ty;

   logic        c_in_ready, c_valid, c_wen, c_ill;
   logic [63:0] c_pc, c_imm;
   logic [6:0]  c_opc, c_f7;
   logic [4:0]  c_rd, c_rs1, c_rs2;
   logic [2:0]  c_f3, c_ty;

   ysyx_24070017_idu_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
      .in_pc(in_pc[31:0]), .flush(flush), .out_valid(a_valid), .out_ready(out_ready),
      .out_pc(a_pc), .out_opcode(a_opc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
      .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_imm_type(a_ty),
      .out_rd_wen(a_wen), .out_illegal(a_ill));

   ysyx_24070017_idu_stage #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(b_valid), .out_ready(out_ready),
      .out_pc(b_pc), .out_opcode(b_opc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
      .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_imm_type(b_ty),
      .out_rd_wen(b_wen), .out_illegal(b_ill));

   ysyx_24070017_idu_stage #(.XLEN(64), .RV64_OPS(1'b0)) dut64n (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .flush(flush), .out_valid(c_valid), .out_ready(out_ready),
      .out_pc(c_pc), .out_opcode(c_opc), .out_rd(c_rd), .out_rs1(c_rs1), .out_rs2(c_rs2),
      .out_funct3(c_f3), .out_funct7(c_f7), .out_imm(c_imm), .out_imm_type(c_ty),
      .out_rd_wen(c_wen), .out_illegal(c_ill));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_err = 0;
   vec_t q[$];
   vec_t cur;
   logic mv = 1'b0;
   vec_t tbl[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1'b1;
      in_inst  = v.inst;
      in_pc    = v.pc;
      cur      = v;
      cyc();
   endtask

   function automatic vec_t mk(input logic [31:0] inst, input logic [63:0] pc, input logic [31:0] imm,
                               input logic [2:0] ty, input logic wen, input logic ill);
      vec_t v;
      v.inst = inst; v.pc = pc; v.imm = imm; v.ty = ty; v.wen = wen; v.ill = ill;
      return v;
   endfunction

   // scoreboard: model of the valid bit, push on modelled accept, compare while held
   always @(negedge clk) begin
      vec_t e;
      logic acc;
      if (rst) begin
         mv = 1'b0;
         q.delete();
      end else begin
         chk("out_valid", a_valid, mv);
         chk("in_ready", a_in_ready, !mv || out_ready);
         if (mv) begin
            chk("scoreboard depth", q.size(), 1);
            if (q.size() > 0) begin
               e = q[0];
               chk("out_pc", a_pc, e.pc[31:0]);
               chk("out_opcode", a_opc, e.inst[6:0]);
               chk("out_rd", a_rd, e.inst[11:7]);
               chk("out_rs1/rs2", {a_rs1, a_rs2}, {e.inst[19:15], e.inst[24:20]});
               chk("out_funct3/7", {a_f3, a_f7}, {e.inst[14:12], e.inst[31:25]});
               chk("out_imm", a_imm, e.imm);
               chk("out_imm_type", a_ty, e.ty);
               chk("out_rd_wen", a_wen, e.wen);
               chk("out_illegal", a_ill, e.ill);
               if (out_ready) void'(q.pop_front());
            end
         end
         acc = in_valid && (!mv || out_ready) && !flush;
         if (flush) begin
            q.delete();
            mv = 1'b0;
         end else if (acc) begin
            q.push_back(cur);
            mv = 1'b1;
         end else if (mv && out_ready) begin
            mv = 1'b0;
         end
      end
   end

   initial begin
      tbl[0]  = mk(32'hFFF00093, 64'h80000000, 32'hFFFFFFFF, 3'd1, 1'b1, 1'b0);
      tbl[1]  = mk(32'h0020A423, 64'h80000004, 32'h00000008, 3'd2, 1'b0, 1'b0);
      tbl[2]  = mk(32'hFE000EE3, 64'h80000008, 32'hFFFFFFFC, 3'd3, 1'b0, 1'b0);
      tbl[3]  = mk(32'h123452B7, 64'h8000000C, 32'h12345000, 3'd4, 1'b1, 1'b0);
      tbl[4]  = mk(32'h008000EF, 64'h80000010, 32'h00000008, 3'd5, 1'b1, 1'b0);
      tbl[5]  = mk(32'hFFDFF06F, 64'h80000014, 32'hFFFFFFFC, 3'd5, 1'b0, 1'b0);
      tbl[6]  = mk(32'h002081B3, 64'h80000018, 32'h00000000, 3'd0, 1'b1, 1'b0);
      tbl[7]  = mk(32'hFFFFF517, 64'h8000001C, 32'hFFFFF000, 3'd4, 1'b1, 1'b0);
      tbl[8]  = mk(32'hFF812303, 64'h80000020, 32'hFFFFFFF8, 3'd1, 1'b1, 1'b0);
      tbl[9]  = mk(32'h300022F3, 64'h80000024, 32'h00000300, 3'd1, 1'b1, 1'b0);
      tbl[10] = mk(32'h000002F3, 64'h80000028, 32'h00000000, 3'd1, 1'b0, 1'b0);
      tbl[11] = mk(32'h0FF0008F, 64'h8000002C, 32'h000000FF, 3'd1, 1'b0, 1'b0);
      tbl[12] = mk(32'h00000010, 64'h80000030, 32'h00000000, 3'd0, 1'b0, 1'b1);
      tbl[13] = mk(32'hFFF0809B, 64'h80000034, 32'h00000000, 3'd0, 1'b0, 1'b1);
      tbl[14] = mk(32'h00209863, 64'h80000038, 32'h00000010, 3'd3, 1'b0, 1'b0);
      tbl[15] = mk(32'hFE320FA3, 64'h8000003C, 32'hFFFFFFFF, 3'd2, 1'b0, 1'b0);

      rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
      cur = tbl[0];
      #3;
      chk("reset out_valid", {a_valid, b_valid, c_valid}, 3'b000);
      chk("reset out_pc", a_pc, 0);
      chk("reset out_imm", a_imm, 0);
      chk("reset fields", {a_opc, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_ty, a_wen, a_ill}, 0);
      chk("reset in_ready", a_in_ready, 1);
      cyc();
      rst = 1'b0;
      cyc();

      // back-to-back stream with out_ready held high
      for (int i = 0; i < 16; i++) drive(tbl[i]);
      in_valid = 1'b0;
      cyc(); cyc();

      // backpressure: lui held while auipc waits
      out_ready = 1'b0;
      drive(tbl[3]);
      cur = tbl[7]; in_inst = tbl[7].inst; in_pc = tbl[7].pc;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp in_ready", a_in_ready, 0);
         chk("bp held imm", a_imm, 32'h12345000);
      end
      out_ready = 1'b1;
      cyc();
      chk("bp release out_valid", a_valid, 1);
      chk("bp release pc", a_pc, 32'h8000001C);
      in_valid = 1'b0;
      cyc(); cyc();

      // flush while holding one and offering another
      out_ready = 1'b0;
      drive(tbl[0]);
      flush = 1'b1; cur = tbl[6]; in_inst = tbl[6].inst; in_pc = tbl[6].pc;
      cyc();
      chk("flush out_valid", a_valid, 0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      chk("flush no capture", a_valid, 0);
      cyc();

      // RV64 variants
      drive(mk(32'hFFF0809B, 64'h0000000180000000, 32'h0, 3'd0, 1'b0, 1'b1));
      chk("rv64 addiw illegal", b_ill, 0);
      chk("rv64 addiw imm", b_imm, 64'hFFFFFFFFFFFFFFFF);
      chk("rv64 addiw type/wen", {b_ty, b_wen}, {3'd1, 1'b1});
      chk("rv64 pc", b_pc, 64'h0000000180000000);
      chk("rv64 no-ops addiw illegal", c_ill, 1);
      chk("rv64 no-ops addiw imm", c_imm, 0);
      drive(mk(32'h800000B7, 64'h0000000180000004, 32'h80000000, 3'd4, 1'b1, 1'b0));
      chk("rv64 lui imm", b_imm, 64'hFFFFFFFF80000000);
      chk("rv64 no-ops lui legal", {c_ill, c_ty}, {1'b0, 3'd4});
      in_valid = 1'b0;
      cyc(); cyc();

      // reset mid-hold clears outputs without waiting for a clock
      out_ready = 1'b0;
      drive(tbl[4]);
      in_valid = 1'b0;
      cyc();
      #2 rst = 1'b1;
      #1;
      chk("midreset out_valid", {a_valid, b_valid, c_valid}, 3'b000);
      chk("midreset out_pc", a_pc, 0);
      chk("midreset out_imm/wen", {a_imm, a_wen}, 0);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      cyc(); cyc();
      chk("scoreboard drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
